// File: rtl/sram_pkg.sv
// Shared definitions for the SRAM read path: read FSM states and the analog
// rail/threshold constants used by the top-level converters.
package sram_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SETTLE  = 2'd1,
    CAPTURE = 2'd2,
    SHIFT   = 2'd3
  } rd_state_e;

  // Volts; one definition for every D/A and threshold stage at the top level.
  localparam real VDD = 1.2;
  localparam real VSS = 0.0;
  localparam real VTH = 0.6;

endpackage

// File: rtl/sram_read_serializer_if.sv
// Read request, array-side and serial-side signals of the SRAM read serializer.
// slave = the serializer, master = whoever issues requests and consumes bits.
interface sram_read_serializer_if #(
  parameter int ROWS = 16,
  parameter int COLS = 8
);
  localparam int AW = (ROWS > 1) ? $clog2(ROWS) : 1;

  logic            rd_req;
  logic [AW-1:0]   rd_addr;
  logic            rd_busy;
  logic            err;
  logic [AW-1:0]   row_sel_rd;
  logic            r_en;
  logic [COLS-1:0] data_out;
  logic            serial_out;
  logic            serial_valid;
  logic            serial_ready;
  logic            last;
  logic            done;

  modport master (
    output rd_req, rd_addr, data_out, serial_ready,
    input  rd_busy, err, row_sel_rd, r_en, serial_out, serial_valid, last, done
  );

  modport slave (
    input  rd_req, rd_addr, data_out, serial_ready,
    output rd_busy, err, row_sel_rd, r_en, serial_out, serial_valid, last, done
  );

endinterface

// File: rtl/sram_read_serializer_piso.sv
// Parallel-in/serial-out register; mirror of the write-side loader.
// load wins over shift; the head bit is always visible on serial_out.
module piso #(
  parameter int COLS      = 8,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic            clk,
  input  logic            arst,
  input  logic            load,
  input  logic            shift,
  input  logic [COLS-1:0] parallel_in,
  output logic            serial_out
);

  logic [COLS-1:0] sr_q;
  logic [COLS-1:0] sr_d;
  logic [COLS-1:0] shifted;

  if (MSB_FIRST) begin : g_msb
    assign shifted    = {sr_q[COLS-2:0], 1'b0};
    assign serial_out = sr_q[COLS-1];
  end else begin : g_lsb
    assign shifted    = {1'b0, sr_q[COLS-1:1]};
    assign serial_out = sr_q[0];
  end

  always_comb begin
    sr_d = sr_q;
    if (load) begin
      sr_d = parallel_in;
    end else if (shift) begin
      sr_d = shifted;
    end
  end

  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      sr_q <= '0;
    end else begin
      sr_q <= sr_d;
    end
  end

endmodule

// File: rtl/sram_read_serializer.sv
// SRAM read controller: selects a row, waits SETTLE cycles with r_en high,
// captures the sensed word and streams it out under valid/ready.
module sram_read_serializer
  import sram_pkg::rd_state_e;
#(
  parameter int ROWS      = 16,
  parameter int COLS      = 8,
  parameter int SETTLE    = 2,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic                    clk,
  input  logic                    arst,
  sram_read_serializer_if.slave   bus
);

  localparam int AW = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam int CW = (SETTLE > 1) ? $clog2(SETTLE) : 1;
  localparam int BW = (COLS > 1) ? $clog2(COLS) : 1;

  localparam logic [AW:0]   ROWS_W   = (AW+1)'(ROWS);
  localparam logic [CW-1:0] CNT_LOAD = CW'(SETTLE - 1);
  localparam logic [BW-1:0] IDX_LAST = BW'(COLS - 1);

  rd_state_e     state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [BW-1:0] idx_q, idx_d;
  logic [AW-1:0] row_q, row_d;
  logic          err_q, err_d;
  logic          done_q, done_d;

  logic          shifting;
  logic          xfer;
  logic          head_bit;

  assign shifting = (state_q == sram_pkg::SHIFT);
  assign xfer     = shifting & bus.serial_ready;

  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      state_q <= sram_pkg::IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      row_q   <= '0;
      err_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      row_q   <= row_d;
      err_q   <= err_d;
      done_q  <= done_d;
    end
  end

  // Requests are only looked at in IDLE; anything arriving later is dropped.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    row_d   = row_q;
    err_d   = 1'b0;
    done_d  = 1'b0;
    case (state_q)
      sram_pkg::IDLE: begin
        if (bus.rd_req) begin
          if ({1'b0, bus.rd_addr} < ROWS_W) begin
            row_d   = bus.rd_addr;
            cnt_d   = CNT_LOAD;
            state_d = sram_pkg::SETTLE;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      sram_pkg::SETTLE: begin
        if (cnt_q == '0) begin
          state_d = sram_pkg::CAPTURE;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      sram_pkg::CAPTURE: begin
        idx_d   = '0;
        state_d = sram_pkg::SHIFT;
      end
      sram_pkg::SHIFT: begin
        if (xfer) begin
          if (idx_q == IDX_LAST) begin
            idx_d   = '0;
            done_d  = 1'b1;
            state_d = sram_pkg::IDLE;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
      end
      default: state_d = sram_pkg::IDLE;
    endcase
  end

  always_comb begin
    bus.rd_busy      = (state_q != sram_pkg::IDLE);
    bus.r_en         = (state_q == sram_pkg::SETTLE) || (state_q == sram_pkg::CAPTURE);
    bus.serial_valid = shifting;
    bus.serial_out   = shifting & head_bit;
    bus.last         = shifting && (idx_q == IDX_LAST);
  end

  assign bus.err        = err_q;
  assign bus.done       = done_q;
  assign bus.row_sel_rd = row_q;

  piso #(
    .COLS      (COLS),
    .MSB_FIRST (MSB_FIRST)
  ) u_piso (
    .clk         (clk),
    .arst        (arst),
    .load        (state_q == sram_pkg::CAPTURE),
    .shift       (xfer),
    .parallel_in (bus.data_out),
    .serial_out  (head_bit)
  );

endmodule

// File: tb/tb_sram_read_serializer.sv
// Directed bench: two serializers (16 rows MSB-first, 12 rows LSB-first) share
// clock, reset and stimulus; every cycle of each read is checked on both.
module tb_sram_read_serializer;

  logic       clk = 1'b0;
  logic       arst;
  logic       rd_req;
  logic [3:0] rd_addr;
  logic [7:0] data_out;
  logic       serial_ready;

  int n_tests = 0;
  int n_fail  = 0;
  int dc;

  always #5 clk = ~clk;

  sram_read_serializer_if #(.ROWS(16), .COLS(8)) ia ();
  sram_read_serializer_if #(.ROWS(12), .COLS(8)) ib ();

  assign ia.rd_req       = rd_req;
  assign ia.rd_addr      = rd_addr;
  assign ia.data_out     = data_out;
  assign ia.serial_ready = serial_ready;
  assign ib.rd_req       = rd_req;
  assign ib.rd_addr      = rd_addr;
  assign ib.data_out     = data_out;
  assign ib.serial_ready = serial_ready;

  sram_read_serializer #(.ROWS(16), .COLS(8), .SETTLE(2), .MSB_FIRST(1'b1)) dut_a (
    .clk  (clk),
    .arst (arst),
    .bus  (ia)
  );

  sram_read_serializer #(.ROWS(12), .COLS(8), .SETTLE(2), .MSB_FIRST(1'b0)) dut_b (
    .clk  (clk),
    .arst (arst),
    .bus  (ib)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // {busy, r_en, valid, serial_out, last, done, err, row[3:0]}
  function automatic logic [10:0] pack(input logic busy, ren, vld, so, lst, dn, er,
                                       input logic [3:0] row);
    return {busy, ren, vld, so, lst, dn, er, row};
  endfunction

  function automatic logic [10:0] obs_a();
    return pack(ia.rd_busy, ia.r_en, ia.serial_valid, ia.serial_out, ia.last,
                ia.done, ia.err, ia.row_sel_rd);
  endfunction

  function automatic logic [10:0] obs_b();
    return pack(ib.rd_busy, ib.r_en, ib.serial_valid, ib.serial_out, ib.last,
                ib.done, ib.err, ib.row_sel_rd);
  endfunction

  task automatic chk_zero(input string tag);
    chk({tag, "_a"}, 32'(obs_a()), 32'd0);
    chk({tag, "_b"}, 32'(obs_b()), 32'd0);
  endtask

  // Called at a negedge that is cycle 0 of the read; returns at the negedge of
  // the done cycle (or right after an abort), leaving rd_req low.
  task automatic do_read(input logic [3:0] addr, input logic [7:0] word,
                         input int stall_from, input int stall_to,
                         input bit poke, input bit scramble, input int abort_k,
                         output int done_cyc);
    int   idx;
    bit   fin;
    bit   done_pend;
    bit   nxt_done;
    logic e_busy, e_ren, e_vld, e_last, e_done, e_bit_a, e_bit_b;
    idx       = 0;
    fin       = 1'b0;
    done_pend = 1'b0;
    done_cyc  = -1;
    rd_req    = 1'b1;
    rd_addr   = addr;
    data_out  = word;
    for (int k = 1; k <= 40 && !fin; k++) begin
      @(negedge clk);
      rd_req       = 1'b0;
      serial_ready = !(k >= stall_from && k <= stall_to);
      e_done  = done_pend;
      e_ren   = (k <= 3);
      e_vld   = (k >= 4) && (idx < 8);
      e_bit_a = e_vld ? word[7-idx] : 1'b0;
      e_bit_b = e_vld ? word[idx] : 1'b0;
      e_last  = e_vld && (idx == 7);
      e_busy  = e_ren || e_vld;
      chk($sformatf("rd_a@%0d", k), 32'(obs_a()),
          32'(pack(e_busy, e_ren, e_vld, e_bit_a, e_last, e_done, 1'b0, addr)));
      chk($sformatf("rd_b@%0d", k), 32'(obs_b()),
          32'(pack(e_busy, e_ren, e_vld, e_bit_b, e_last, e_done, 1'b0, addr)));
      nxt_done = e_vld && serial_ready && (idx == 7);
      if (e_vld && serial_ready) idx++;
      done_pend = nxt_done;
      if (e_done) begin
        fin      = 1'b1;
        done_cyc = k;
      end
      if (poke && k == 6) begin
        rd_req  = 1'b1;
        rd_addr = 4'd3;
      end
      if (scramble && k == 4) data_out = 8'h00;
      if (k == abort_k) begin
        #2 arst = 1'b1;
        #1 chk_zero($sformatf("abort@%0d", k));
        fin = 1'b1;
      end
    end
    chk("read_finished", 32'(fin), 32'd1);
  endtask

  initial begin
    arst         = 1'b1;
    rd_req       = 1'b0;
    rd_addr      = '0;
    data_out     = '0;
    serial_ready = 1'b1;
    repeat (2) @(negedge clk);
    arst = 1'b0;
    chk_zero("reset_state");

    // Asynchronous reset in the middle of a settle phase.
    @(negedge clk);
    rd_req  = 1'b1;
    rd_addr = 4'd5;
    @(negedge clk);
    rd_req = 1'b0;
    @(negedge clk);
    chk("pre_rst_ren_a", 32'(ia.r_en), 32'd1);
    #2 arst = 1'b1;
    #1 chk_zero("async_rst");
    @(negedge clk);
    arst = 1'b0;

    @(negedge clk);
    do_read(4'd5, 8'hA5, 0, -1, 1'b0, 1'b0, 0, dc);
    chk("basic_done_cyc", 32'(dc), 32'd12);

    @(negedge clk);
    do_read(4'd5, 8'hA5, 5, 7, 1'b0, 1'b0, 0, dc);
    chk("bp_done_cyc", 32'(dc), 32'd15);

    // Ignored mid-read request, late data change, then a request in the done cycle.
    @(negedge clk);
    do_read(4'd5, 8'hA5, 0, -1, 1'b1, 1'b1, 0, dc);
    chk("poke_done_cyc", 32'(dc), 32'd12);
    do_read(4'd9, 8'h3C, 0, -1, 1'b0, 1'b0, 0, dc);
    chk("chain_done_cyc", 32'(dc), 32'd12);

    // Out-of-range only for the 12-row instance.
    @(negedge clk);
    rd_req  = 1'b1;
    rd_addr = 4'd13;
    @(negedge clk);
    rd_req = 1'b0;
    chk("rej_err_b", 32'(ib.err), 32'd1);
    chk("rej_busy_b", 32'(ib.rd_busy), 32'd0);
    chk("rej_ren_b", 32'(ib.r_en), 32'd0);
    chk("rej_accept_a", 32'(ia.rd_busy), 32'd1);
    for (int k = 2; k <= 4; k++) begin
      @(negedge clk);
      chk($sformatf("rej_after_b@%0d", k), 32'({ib.err, ib.rd_busy, ib.r_en}), 32'd0);
    end
    repeat (12) @(negedge clk);
    chk("rej_a_idle", 32'(ia.rd_busy), 32'd0);

    // Abort while bit 3 is on the line, then a clean read.
    @(negedge clk);
    do_read(4'd6, 8'hA5, 0, -1, 1'b0, 1'b0, 7, dc);
    @(negedge clk);
    arst = 1'b0;
    for (int k = 1; k <= 3; k++) begin
      @(negedge clk);
      chk($sformatf("post_abort@%0d", k),
          32'({ia.done, ib.done, ia.serial_valid, ib.serial_valid}), 32'd0);
    end
    do_read(4'd2, 8'h01, 0, -1, 1'b0, 1'b0, 0, dc);
    chk("fresh_done_cyc", 32'(dc), 32'd12);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/sram_read_serializer.md
# sram_read_serializer

Read-side controller and parallel-in/serial-out converter for the mixed-signal SRAM. It accepts a row read request and drives the digital read-row select and read enable into the read decoder/sense-amp path. After a programmable settle time it captures the thresholded COLS-bit word and shifts it out one bit at a time under a valid/ready handshake. It is the output-side counterpart of the serial-in/parallel-out write loader.

## Interface
- ROWS, 16, number of array rows
- COLS, 8, word width / number of columns
- SETTLE, 2, cycles the address and r_en are held before capture; must be >= 1
- MSB_FIRST, 1, 1 = bit COLS-1 shifted first, 0 = bit 0 first
- AW (localparam), $clog2(ROWS), address width

Ports:
- clk  in  1  single clock, rising edge
- arst  in  1  asynchronous reset, active-high
- rd_req  in  1  read request, sampled only in IDLE
- rd_addr  in  AW  row to read, sampled with rd_req
- rd_busy  out  1  high in every state other than IDLE
- err  out  1  one-cycle pulse on rejected request (rd_addr >= ROWS)
- row_sel_rd  out  AW  row address toward the read decoder (D/A at top level)
- r_en  out  1  read enable toward the array/sense path
- data_out  in  COLS  thresholded sense-amp word
- serial_out  out  1  current serial bit
- serial_valid  out  1  serial_out holds a valid bit
- serial_ready  in  1  downstream accepts the bit
- last  out  1  qualifies the final bit of the word (only while serial_valid)
- done  out  1  one-cycle pulse after the final bit transfers

## Operation
- FSM states: IDLE, SETTLE, CAPTURE, SHIFT.
- IDLE, rd_req=1, rd_addr < ROWS:
  - Register rd_addr into row_sel_rd.
  - Go to SETTLE with the counter loaded to SETTLE-1.
- IDLE, rd_req=1, rd_addr >= ROWS: pulse err next cycle and stay in IDLE.
- SETTLE:
  - r_en=1, and row_sel_rd is held.
  - The counter decrements each cycle; at 0, go to CAPTURE.
- CAPTURE: r_en=1 for one cycle; data_out is loaded into the shift register at the end of the cycle, and the state goes to SHIFT.
- SHIFT:
  - r_en=0, serial_valid=1, and serial_out is the current head bit.
  - The bit index advances only when serial_valid && serial_ready.
  - last=1 while the index equals COLS-1.
  - Transfer of the last bit goes to IDLE with done=1 in the following cycle.
- Output stability: while serial_valid && !serial_ready, serial_out and last stay stable.
- Outside SHIFT: serial_valid=0, serial_out=0, last=0.
- Requests outside IDLE: rd_req in any non-IDLE state is ignored, not queued.
- Request in the done cycle: rd_req in the IDLE cycle carrying done is accepted normally.
- Capture isolation: changes on data_out outside the CAPTURE cycle have no effect on the shifted word.
- row_sel_rd holds its last value in IDLE.

## Timing
- Reset: when arst is asserted, every output goes to 0 immediately, regardless of clk.
  - Outputs cleared: rd_busy, err, row_sel_rd, r_en, serial_out, serial_valid, last, done.
  - State goes to IDLE; the counters and shift register clear.
- Reset mid-operation aborts the read with no done pulse. The first rising edge after arst deasserts may accept rd_req.
- Read timeline, with rd_req sampled at cycle 0:
  - Cycles 1..SETTLE: SETTLE state, r_en=1.
  - Cycle SETTLE+1: CAPTURE.
  - First serial_valid at cycle SETTLE+2.
- With serial_ready held high:
  - Bits occupy cycles SETTLE+2 .. SETTLE+1+COLS.
  - done and rd_busy=0 at cycle SETTLE+2+COLS.
  - Each low-ready cycle during SHIFT adds one cycle.
- err is high exactly one cycle, the cycle after the rejected request.

## Structure
- Shared package sram_pkg holds:
  - typedef enum rd_state_e {IDLE, SETTLE, CAPTURE, SHIFT};
  - rail/threshold constants VDD, VSS, VTH, so top-level converters use one definition.
- One sub-module, piso (parameter COLS, MSB_FIRST), the mirror of the write-side loader:
  - Ports clk, arst, load, shift, parallel_in[COLS-1:0], serial_out.
  - load has priority over shift.
- The FSM, settle counter and bit counter live in sram_read_serializer.

## Test plan
- Reset: assert arst mid-cycle with ROWS=16, COLS=8, SETTLE=2 -> all outputs 0 without waiting for a clock edge; state is IDLE.
- Basic read: rd_req, rd_addr=5, data_out=8'hA5, ready=1, MSB_FIRST=1.
  - row_sel_rd=5 and r_en=1 in cycles 1-3.
  - Bits 1,0,1,0,0,1,0,1 in cycles 4-11, last in cycle 11, done in cycle 12.
- Backpressure: as the basic read, with serial_ready=0 in cycles 5-7 -> the bit-1 value (0) is held in cycles 5-8, last in cycle 14, done in cycle 15.
- Request handling and capture isolation:
  - rd_req in cycle 6 of a read -> ignored.
  - rd_req in the done cycle with addr=9 -> accepted; the second read starts the next cycle.
  - data_out changed to 8'h00 after CAPTURE -> the shifted word remains 8'hA5.
- Rejection: ROWS=12, rd_req with rd_addr=13 -> err=1 for one cycle, rd_busy stays 0, r_en never asserted.
- Abort: arst during SHIFT (bit 3) -> serial_valid drops immediately with no done; a fresh read with MSB_FIRST=0 and data_out=8'h01 shifts 1,0,0,0,0,0,0,0.
